alu_issue_controller: RTL
=========================

Name: alu_issue_controller

Overview:
- Multicycle initiator for the team's combinational ALU: accepts 9-bit instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives SrcA/SrcB/ALUControl to the ALU, captures ALUResult/Zero, and writes the result back.
- Sits between the board switch/keys front-end and the ALU on the DE10-Lite datapath.

Parameters:
- WIDTH, 4, data width of registers, operands and result.
- NREGS, 4, number of registers; fixed at 4 (2-bit register addresses).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- InstrValid  in  1  instruction present.
- InstrReady  out  1  controller can accept an instruction.
- Instr  in  9  op[8:6], rd[5:4], rs[3:2], rt[1:0].
- SrcA  out  WIDTH  ALU operand A.
- SrcB  out  WIDTH  ALU operand B.
- ALUControl  out  3  ALU operation select.
- ALUResult  in  WIDTH  ALU result.
- Zero  in  1  ALU zero flag.
- Done  out  1  one-cycle pulse when an instruction retires.
- ResultOut  out  WIDTH  last captured/written value.
- ZeroFlag  out  1  registered Zero from last ALU op.
- Error  out  1  sticky illegal-op flag.
- Mismatch  out  1  sticky self-check flag (see Optional Feature).
- RdAddr  in  2  debug register read address.
- RdData  out  WIDTH  combinational read of reg[RdAddr].

Behaviour:
- Reset (synchronous, active-high; the only reset in the block):
  - Takes effect on the clock edge; clk is the only clock.
  - State=IDLE, all regs=0, SrcA=SrcB=0, ALUControl=3'b111, Done=0, ResultOut=0, ZeroFlag=0, Error=0, Mismatch=0.
  - InstrReady=0 while reset is high.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT: issued to the ALU with the same code.
  - 110 CMP: issues 001 and updates flags only; no register write.
  - 111 LOADI: reg[rd] <= {rs,rt} zero-extended/truncated to WIDTH; no ALU use.
  - 100: illegal.
- Arithmetic: results modulo 2^WIDTH; SLT is an unsigned compare, result 0 or 1.
- FSM states: IDLE, ISSUE, CAPTURE, WRITEBACK.
  - IDLE: InstrReady=1; ALUControl parked at 3'b111. On InstrValid&&InstrReady, latch Instr.
    - ALU ops -> ISSUE.
    - LOADI or illegal -> WRITEBACK.
  - ISSUE: SrcA=reg[rs], SrcB=reg[rt] (registered at accept), ALUControl=op -> CAPTURE.
  - CAPTURE: operands held; at the end of the cycle, register ALUResult into ResultOut and Zero into ZeroFlag -> WRITEBACK.
  - WRITEBACK: write reg[rd] (ALU ops except CMP, and LOADI; LOADI also updates ResultOut). Illegal op sets Error, no write. Done=1 for exactly this cycle -> IDLE.
- Park code: ALUControl returns to 3'b111 in IDLE/WRITEBACK, so every issued op presents a transition on ALUControl.
- Latency: accept at edge N; Done high in cycle N+3 for ALU ops, N+1 for LOADI/illegal. Max throughput is 1 ALU op per 4 cycles.
- InstrReady=0 in ISSUE/CAPTURE/WRITEBACK; InstrValid is ignored there, and the instruction is not captured.
- rd==rs or rd==rt is legal: operands are captured before writeback.
- RdData shows the new value from the cycle after the WRITEBACK edge.
- Reset mid-instruction: no register write, no Done, Error/Mismatch cleared.

Optional Feature:
- Macro ALU_SELFCHECK_EN.
- Defined: in CAPTURE the controller computes the expected result internally (same op table). Mismatch sets sticky if ALUResult or Zero disagrees; it is cleared only by reset.
- Undefined: no reference model is built; Mismatch is tied 0.

Test Plan:
- Reset; LOADI r1=5, LOADI r2=3, ADD r3=r1+r2 -> RdData(r3)=8, ZeroFlag=0, Done exactly 3 cycles after the ADD accept.
- SUB r0=r2-r1 (3-5) -> r0=14, ZeroFlag=0; then CMP r1,r1 -> ZeroFlag=1, all registers unchanged.
- With r1=5, r2=3: AND -> 1, OR -> 7, SLT r2<r1 -> 1, SLT r1<r2 -> 0; ALUControl observed toggling 111->op->111 each time.
- Op 100 -> Error=1 and stays 1 across later legal ops; Done pulses one cycle after accept; no register change; ALUControl stays 111.
- Assert reset during CAPTURE of ADD r3 -> r3 stays 0, no Done, InstrReady=0 during reset and 1 the cycle after release.
- InstrValid held high with 3 queued ADDs -> accepted at cycles 0, 4, 8; Mismatch=0 with ALU_SELFCHECK_EN and a correct ALU; forcing ALUResult wrong in CAPTURE sets Mismatch=1.

Source files
------------

// File: rtl/alu_issue_controller.sv
// Multicycle issue controller for the combinational ALU with a 4-entry register file.
// Optional macro ALU_SELFCHECK_EN builds a reference model that flags ALU disagreements on Mismatch.
module alu_issue_controller #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    output logic             InstrReady,
    input  logic [8:0]       Instr,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero,
    output logic             Done,
    output logic [WIDTH-1:0] ResultOut,
    output logic             ZeroFlag,
    output logic             Error,
    output logic             Mismatch,
    input  logic [1:0]       RdAddr,
    output logic [WIDTH-1:0] RdData
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITEBACK} state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_ILL   = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_CMP   = 3'b110;
    localparam logic [2:0] OP_LOADI = 3'b111;
    localparam logic [2:0] PARK     = 3'b111;

    state_t           state_q, state_d;
    logic [8:0]       instr_q;
    logic [WIDTH-1:0] srca_q, srcb_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             error_q;
    logic             accept;
    logic [2:0]       op_q;
    logic [1:0]       rd_q;
    logic [2:0]       issue_code;
    logic [WIDTH-1:0] imm;

    assign op_q       = instr_q[8:6];
    assign rd_q       = instr_q[5:4];
    // CMP reuses the subtractor; only the flags are kept
    assign issue_code = (op_q == OP_CMP) ? OP_SUB : op_q;
    assign imm        = WIDTH'(instr_q[3:0]);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        InstrReady = 1'b0;
        Done       = 1'b0;
        ALUControl = PARK;
        case (state_q)
            IDLE: begin
                InstrReady = !reset;
                accept     = InstrValid && !reset;
                if (accept) begin
                    if (Instr[8:6] == OP_LOADI || Instr[8:6] == OP_ILL)
                        state_d = WRITEBACK;
                    else
                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                ALUControl = issue_code;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                ALUControl = issue_code;
                state_d    = WRITEBACK;
            end
            WRITEBACK: begin
                Done    = !reset;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= Instr;
                srca_q  <= regs_q[Instr[3:2]];
                srcb_q  <= regs_q[Instr[1:0]];
            end
            if (state_q == CAPTURE) begin
                result_q <= ALUResult;
                zero_q   <= Zero;
            end
            if (state_q == WRITEBACK) begin
                case (op_q)
                    OP_LOADI: begin
                        regs_q[rd_q] <= imm;
                        result_q     <= imm;
                    end
                    OP_ILL: error_q <= 1'b1;
                    OP_CMP: ;
                    default: regs_q[rd_q] <= result_q;
                endcase
            end
        end
    end

`ifdef ALU_SELFCHECK_EN
    logic [WIDTH-1:0] exp_result;
    logic             mismatch_q;

    always_comb begin
        exp_result = '0;
        case (issue_code)
            OP_ADD:  exp_result = srca_q + srcb_q;
            OP_SUB:  exp_result = srca_q - srcb_q;
            OP_AND:  exp_result = srca_q & srcb_q;
            OP_OR:   exp_result = srca_q | srcb_q;
            OP_SLT:  exp_result = WIDTH'(srca_q < srcb_q);
            default: exp_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            mismatch_q <= 1'b0;
        else if (state_q == CAPTURE &&
                 (ALUResult != exp_result || Zero != (exp_result == '0)))
            mismatch_q <= 1'b1;
    end

    assign Mismatch = mismatch_q;
`else
    assign Mismatch = 1'b0;
`endif

    assign SrcA      = srca_q;
    assign SrcB      = srcb_q;
    assign ResultOut = result_q;
    assign ZeroFlag  = zero_q;
    assign Error     = error_q;
    assign RdData    = regs_q[RdAddr];

endmodule
